// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
// Optional checksum logic elsewhere is enabled with INSTR_RAM_LOADER_CHECKSUM_EN.
package instr_loader_pkg;

  localparam int LOADER_RAM_DEPTH  = 1024;
  localparam int LOADER_ADDR_W     = $clog2(LOADER_RAM_DEPTH);
  localparam int LOADER_DATA_W     = 32;
  localparam int BOOT_BASE_DEFAULT = 0;
  localparam int BOOT_LEN_DEFAULT  = 97;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_DONE
  } loader_state_t;

endpackage

// File: rtl/instr_loader_checksum.sv
// Modulo-2^DATA_W running sum of the words written during one load.
// Only instantiated when INSTR_RAM_LOADER_CHECKSUM_EN is defined.
module instr_loader_checksum
  import instr_loader_pkg::*;
#(
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_word;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/instr_ram_loader.sv
// Copies a block of source words into the instruction RAM while stalling the CPU.
// Define INSTR_RAM_LOADER_CHECKSUM_EN to add the checksum/expectedSum/checksumError ports.
module instr_ram_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W        = LOADER_ADDR_W,
  parameter int DATA_W        = LOADER_DATA_W,
  parameter int BOOT_ON_RESET = 1,
  parameter int BOOT_BASE     = BOOT_BASE_DEFAULT,
  parameter int BOOT_LEN      = BOOT_LEN_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loadRequest,
  input  logic [ADDR_W-1:0] loadBase,
  input  logic [ADDR_W:0]   loadLength,
  output logic              srcRead,
  output logic [ADDR_W-1:0] srcAddress,
  input  logic              srcValid,
  input  logic [DATA_W-1:0] srcData,
  output logic              ramWriteEnable,
  output logic [ADDR_W-1:0] ramWriteAddress,
  output logic [DATA_W-1:0] ramWriteData,
  output logic              cpuStall,
  output logic              busy,
  output logic              loadDone
`ifdef INSTR_RAM_LOADER_CHECKSUM_EN
  ,
  input  logic [DATA_W-1:0] expectedSum,
  output logic [DATA_W-1:0] checksum,
  output logic              checksumError
`endif
);

  localparam loader_state_t     RESET_STATE = (BOOT_ON_RESET != 0) ? S_BOOT : S_IDLE;
  localparam logic [ADDR_W-1:0] BOOT_BASE_V = ADDR_W'(BOOT_BASE);
  localparam logic [ADDR_W:0]   BOOT_LEN_V  = (ADDR_W+1)'(BOOT_LEN);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_offset;
  logic [DATA_W-1:0] r_data;
  logic              r_src_read;
  logic [ADDR_W-1:0] r_src_addr;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_load_done;

  logic              w_start;
  logic [ADDR_W-1:0] w_start_base;
  logic [ADDR_W:0]   w_start_len;
  logic [ADDR_W:0]   w_next_count;

  // Boot and software loads share one start path; only the base/length source differs.
  assign w_start      = (r_state == S_BOOT) || ((r_state == S_IDLE) && loadRequest);
  assign w_start_base = (r_state == S_BOOT) ? BOOT_BASE_V : loadBase;
  assign w_start_len  = (r_state == S_BOOT) ? BOOT_LEN_V : loadLength;
  assign w_next_count = {1'b0, r_offset} + 1'b1;

  // NOTE: every register in this block is assigned with <= so all next-state
  // values are computed from the same pre-edge snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RESET_STATE;
      r_base      <= '0;
      r_len       <= '0;
      r_offset    <= '0;
      r_data      <= '0;
      r_src_read  <= 1'b0;
      r_src_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_wr_addr   <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_ram_we    <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        S_BOOT, S_IDLE: begin
          if (w_start) begin
            r_base   <= w_start_base;
            r_len    <= w_start_len;
            r_offset <= '0;
            if (w_start_len == '0) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_src_read <= 1'b1;
              r_src_addr <= '0;
            end
          end
        end
        S_FETCH: begin
          if (srcValid) begin
            r_data     <= srcData;
            r_src_read <= 1'b0;
            r_ram_we   <= 1'b1;
            r_wr_addr  <= r_base + r_offset;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_offset <= w_next_count[ADDR_W-1:0];
          if (w_next_count == r_len) begin
            r_state     <= S_DONE;
            r_load_done <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_src_read <= 1'b1;
            r_src_addr <= w_next_count[ADDR_W-1:0];
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= RESET_STATE;
      endcase
    end
  end

  assign srcRead         = r_src_read;
  assign srcAddress      = r_src_addr;
  assign ramWriteEnable  = r_ram_we;
  assign ramWriteAddress = r_wr_addr;
  assign ramWriteData    = r_data;
  assign loadDone        = r_load_done;
  // Stall is forced while reset is held so the CPU never runs on a half-loaded RAM.
  assign busy            = !reset && (r_state != S_IDLE);
  assign cpuStall        = reset || busy;

`ifdef INSTR_RAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] w_sum;
  logic              w_cs_add;
  logic              r_cs_err;

  assign w_cs_add = (r_state == S_WRITE);

  instr_loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_start),
    .i_add   (w_cs_add),
    .i_word  (r_data),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clock) begin
    if (reset || w_start) begin
      r_cs_err <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_cs_err <= (w_sum != expectedSum);
    end
  end

  assign checksum      = w_sum;
  assign checksumError = r_cs_err;
`endif

endmodule

// File: tb/tb_instr_ram_loader.sv
// Scoreboard bench for instr_ram_loader: boot, wait states, wrap, zero length, reset mid-load.
// Checksum scenario compiled in when INSTR_RAM_LOADER_CHECKSUM_EN is defined.
module tb_instr_ram_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        loadRequest = 1'b0;
  logic [9:0]  loadBase = '0;
  logic [10:0] loadLength = '0;
  logic        srcRead;
  logic [9:0]  srcAddress;
  logic        srcValid = 1'b0;
  logic [31:0] srcData = '0;
  logic        ramWriteEnable;
  logic [9:0]  ramWriteAddress;
  logic [31:0] ramWriteData;
  logic        cpuStall;
  logic        busy;
  logic        loadDone;
`ifdef INSTR_RAM_LOADER_CHECKSUM_EN
  logic [31:0] expectedSum = '0;
  logic [31:0] checksum;
  logic        checksumError;
`endif

  wr_t         exp_q[$];
  logic [31:0] src_mem[16];
  int          latency = 0;
  bit          spurious = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  instr_ram_loader #(
    .BOOT_ON_RESET (1),
    .BOOT_BASE     (0),
    .BOOT_LEN      (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .loadRequest     (loadRequest),
    .loadBase        (loadBase),
    .loadLength      (loadLength),
    .srcRead         (srcRead),
    .srcAddress      (srcAddress),
    .srcValid        (srcValid),
    .srcData         (srcData),
    .ramWriteEnable  (ramWriteEnable),
    .ramWriteAddress (ramWriteAddress),
    .ramWriteData    (ramWriteData),
    .cpuStall        (cpuStall),
    .busy            (busy),
    .loadDone        (loadDone)
`ifdef INSTR_RAM_LOADER_CHECKSUM_EN
    ,
    .expectedSum     (expectedSum),
    .checksum        (checksum),
    .checksumError   (checksumError)
`endif
  );

  always #5 clock = ~clock;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Source memory model: answers a read after `latency` wait cycles.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clock);
      #1;
      if (srcRead === 1'b1) begin
        if (wait_cnt >= latency) begin
          srcValid = 1'b1;
          srcData  = src_mem[srcAddress[3:0]];
          wait_cnt = 0;
        end else begin
          srcValid = 1'b0;
          srcData  = 32'h0BAD_0BAD;
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        srcValid = spurious;
        srcData  = 32'hDEAD_BEEF;
      end
    end
  end

  // Write monitor: pops the scoreboard and checks the read handshake.
  initial begin : monitor
    bit         prev_hs;
    bit         prev_wait;
    logic [9:0] prev_addr;
    wr_t        exp;
    prev_hs   = 1'b0;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clock);
      if (ramWriteEnable === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                   ramWriteAddress, ramWriteData);
        end else begin
          exp = exp_q.pop_front();
          if (ramWriteAddress !== exp.addr || ramWriteData !== exp.data)
            $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     ramWriteAddress, ramWriteData, exp.addr, exp.data);
          else
            n_pass++;
        end
        n_checks++;
        if (!prev_hs) $display("FAIL write_without_valid: got write, expected preceding srcValid");
        else n_pass++;
      end
      if (prev_wait && srcRead === 1'b1) begin
        n_checks++;
        if (srcAddress !== prev_addr)
          $display("FAIL src_addr_stable: got %0d, expected %0d", srcAddress, prev_addr);
        else
          n_pass++;
      end
      #2;
      prev_hs   = (srcRead === 1'b1) && (srcValid === 1'b1);
      prev_wait = (srcRead === 1'b1) && (srcValid !== 1'b1);
      prev_addr = srcAddress;
    end
  end

  task automatic push_writes(input logic [9:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0] a;
      a = base + 10'(i);
      exp_q.push_back('{addr: a, data: src_mem[i]});
    end
  endtask

  // Counts cycles from FETCH entry to the loadDone pulse inclusive; -1 on timeout.
  task automatic measure(output int cycles);
    int n;
    n = 0;
    cycles = -1;
    for (int i = 0; i < 300; i++) begin
      if (n == 0) begin
        if (srcRead === 1'b1) n = 1;
      end else begin
        n++;
      end
      if (n > 0 && loadDone === 1'b1) begin
        cycles = n;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic request(input logic [9:0] base, input logic [10:0] len);
    @(negedge clock);
    loadRequest = 1'b1;
    loadBase    = base;
    loadLength  = len;
    @(negedge clock);
    loadRequest = 1'b0;
  endtask

  task automatic check_after_done(input string name);
    n_checks++;
    if (cpuStall !== 1'b1) $display("FAIL %s_stall_at_done: got %b, expected 1", name, cpuStall);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (loadDone !== 1'b0) $display("FAIL %s_done_pulse: got %b, expected 0", name, loadDone);
    else n_pass++;
    n_checks++;
    if (cpuStall !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_idle: got stall=%b busy=%b, expected 0 0", name, cpuStall, busy);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_pending: got %0d writes left, expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (ramWriteEnable !== 1'b0 || srcRead !== 1'b0 || loadDone !== 1'b0)
      $display("FAIL reset_outputs: got we=%b rd=%b done=%b, expected 0 0 0",
               ramWriteEnable, srcRead, loadDone);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || cpuStall !== 1'b1)
      $display("FAIL reset_stall: got busy=%b stall=%b, expected 0 1", busy, cpuStall);
    else n_pass++;
  endtask

  task automatic test_boot;
    int cyc;
    for (int i = 0; i < 16; i++) src_mem[i] = 32'hA0 + 32'(i);
    latency = 0;
    push_writes(10'd0, 4);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || cpuStall !== 1'b1)
      $display("FAIL boot_state: got busy=%b stall=%b, expected 1 1", busy, cpuStall);
    else n_pass++;
    @(negedge clock);
    measure(cyc);
    n_checks++;
    if (cyc != 9) $display("FAIL boot_cycles: got %0d, expected 9", cyc);
    else n_pass++;
    check_after_done("boot");
  endtask

  task automatic test_wait_states;
    int cyc;
    for (int i = 0; i < 16; i++) src_mem[i] = 32'h1000 + 32'(i) * 32'h11;
    latency  = 2;
    spurious = 1'b1;
    push_writes(10'd100, 3);
    request(10'd100, 11'd3);
    measure(cyc);
    n_checks++;
    if (cyc != 13) $display("FAIL wait_cycles: got %0d, expected 13", cyc);
    else n_pass++;
    check_after_done("wait");
    latency  = 0;
    spurious = 1'b0;
  endtask

  task automatic test_wrap;
    int cyc;
    for (int i = 0; i < 16; i++) src_mem[i] = 32'h2000 + 32'(i);
    push_writes(10'd1022, 4);
    request(10'd1022, 11'd4);
    measure(cyc);
    n_checks++;
    if (cyc != 9) $display("FAIL wrap_cycles: got %0d, expected 9", cyc);
    else n_pass++;
    check_after_done("wrap");
  endtask

  task automatic test_zero_len;
    @(negedge clock);
    loadRequest = 1'b1;
    loadBase    = 10'd5;
    loadLength  = 11'd0;
    @(negedge clock);
    n_checks++;
    if (loadDone !== 1'b1 || srcRead !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_done: got done=%b rd=%b busy=%b, expected 1 0 1", loadDone, srcRead, busy);
    else n_pass++;
    loadBase   = 10'd9;
    loadLength = 11'd5;
    @(negedge clock);
    loadRequest = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || loadDone !== 1'b0)
      $display("FAIL zero_idle: got busy=%b done=%b, expected 0 0", busy, loadDone);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || srcRead !== 1'b0)
      $display("FAIL req_at_done_ignored: got busy=%b rd=%b, expected 0 0", busy, srcRead);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load;
    int wr;
    int cyc;
    for (int i = 0; i < 16; i++) src_mem[i] = 32'h500 + 32'(i);
    push_writes(10'd200, 2);
    @(negedge clock);
    loadRequest = 1'b1;
    loadBase    = 10'd200;
    loadLength  = 11'd4;
    @(negedge clock);
    loadBase   = 10'd7;
    loadLength = 11'd1;
    @(negedge clock);
    loadRequest = 1'b0;
    wr = 0;
    for (int i = 0; i < 50; i++) begin
      if (ramWriteEnable === 1'b1) wr++;
      if (wr == 2) break;
      @(negedge clock);
    end
    n_checks++;
    if (wr != 2) $display("FAIL midload_writes: got %0d, expected 2", wr);
    else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (ramWriteEnable !== 1'b0 || srcRead !== 1'b0 || cpuStall !== 1'b1)
      $display("FAIL midload_reset: got we=%b rd=%b stall=%b, expected 0 0 1",
               ramWriteEnable, srcRead, cpuStall);
    else n_pass++;
    for (int i = 0; i < 16; i++) src_mem[i] = 32'hC0 + 32'(i);
    push_writes(10'd0, 4);
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midload_boot_state: got busy=%b, expected 1", busy);
    else n_pass++;
    @(negedge clock);
    measure(cyc);
    n_checks++;
    if (cyc != 9) $display("FAIL reboot_cycles: got %0d, expected 9", cyc);
    else n_pass++;
    check_after_done("reboot");
  endtask

`ifdef INSTR_RAM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int cyc;
    src_mem[0] = 32'h1;
    src_mem[1] = 32'h2;
    src_mem[2] = 32'hFFFF_FFFF;
    for (int pass = 0; pass < 2; pass++) begin
      expectedSum = (pass == 0) ? 32'd2 : 32'd3;
      push_writes(10'd300, 3);
      request(10'd300, 11'd3);
      n_checks++;
      if (checksum !== 32'd0) $display("FAIL cs_clear: got %h, expected 0", checksum);
      else n_pass++;
      measure(cyc);
      n_checks++;
      if (checksum !== 32'd2) $display("FAIL cs_sum: got %h, expected 2", checksum);
      else n_pass++;
      check_after_done("cs");
      n_checks++;
      if (checksumError !== (pass == 1))
        $display("FAIL cs_error: got %b, expected %b", checksumError, (pass == 1));
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_boot();
    test_wait_states();
    test_wrap();
    test_zero_len();
    test_reset_mid_load();
`ifdef INSTR_RAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (4) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_pending: got %0d writes left, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
